// File: rtl/scandoubler_vga.sv
// scandoubler_vga: 15 kHz -> 31 kHz line doubler.
// Each input line is captured into one bank of a two-bank line buffer
// while the previously completed line is replayed from the other bank at
// twice the pixel rate. The output stage expands 4-bit RGBI colour to
// 6-bit-per-channel levels and regenerates a narrow output hsync.
module scandoubler_vga #(
   parameter int LINE_MAX = 512,
   parameter int HS_WIDTH = 16,
   parameter int LVL_HI   = 63,
   parameter int LVL_LO   = 42
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pix_ce,
   input  logic       pix2_ce,
   input  logic [3:0] rgbi_in,
   input  logic       hsync_n_in,
   input  logic       vsync_n_in,
   output logic [5:0] vga_r,
   output logic [5:0] vga_g,
   output logic [5:0] vga_b,
   output logic       vga_hs_n,
   output logic       vga_vs_n,
   output logic [8:0] line_len
);

   // Column width is fixed by the 9-bit line_len port.
   localparam int             AW      = 9;
   localparam logic [AW-1:0]  COL_MAX = AW'(LINE_MAX - 1);
   localparam logic [AW-1:0]  HS_COLS = AW'(HS_WIDTH);

   // Two banks stored flat; the bank select is the address MSB.
   logic [3:0]    mem [0:2*LINE_MAX-1];

   logic          hs_prev;
   logic          vs_reg;
   logic          wr_bank;
   logic          rd_bank;
   logic [AW-1:0] wr_col;     // address of the most recently written pixel
   logic [AW-1:0] rd_col;
   logic          seen;       // at least one line start since reset
   logic          valid;      // read bank holds a complete line

   logic [3:0]    rd_data;
   logic          rd_pend;
   logic          rd_valid;
   logic          rd_hs;

   logic          line_start;
   logic [AW-1:0] col_inc;
   logic [AW-1:0] wr_addr;
   logic          wr_sel;
   logic          rd_wrap;

   // Falling edge of the input hsync as seen at pixel strobes.
   assign line_start = pix_ce & hs_prev & ~hsync_n_in;

   // Next column, saturating so an over-long line keeps rewriting the last entry.
   assign col_inc = (wr_col == COL_MAX) ? wr_col : wr_col + 1'b1;

   // The line-start pixel already belongs to the new line in the other bank.
   assign wr_addr = line_start ? '0 : col_inc;
   assign wr_sel  = line_start ? ~wr_bank : wr_bank;

   // Replay wraps after line_len pixels; an empty line parks the pointer at 0.
   assign rd_wrap = (line_len == '0) || (rd_col >= line_len - 1'b1);

   // Line buffer write on input strobes and synchronous read on output strobes.
   // NOTE: the buffer RAM has no reset; it maps onto block RAM and its contents
   // are never seen until valid rises after a full line has been captured.
   always_ff @(posedge clk) begin
      if (pix_ce)
         mem[{wr_sel, wr_addr}] <= rgbi_in;
      if (pix2_ce)
         rd_data <= mem[{rd_bank, rd_col}];
   end

   // Input-side control: sync edge detect, write pointer, bank swap, line length.
   // NOTE: every sequential assignment uses <= so all registers update from the
   // same pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs_prev  <= 1'b1;
         vs_reg   <= 1'b1;
         wr_bank  <= 1'b0;
         rd_bank  <= 1'b0;
         wr_col   <= '0;
         line_len <= '0;
         seen     <= 1'b0;
         valid    <= 1'b0;
         vga_vs_n <= 1'b1;
      end else if (pix_ce) begin
         hs_prev <= hsync_n_in;
         vs_reg  <= vsync_n_in;
         wr_col  <= wr_addr;
         if (line_start) begin
            line_len <= col_inc;
            rd_bank  <= wr_bank;
            wr_bank  <= ~wr_bank;
            seen     <= 1'b1;
            // The first line after reset is partial, so only the second start
            // enables the picture.
            valid    <= seen;
            vga_vs_n <= vs_reg;
         end
      end
   end

   // Output-side read pointer plus the attributes that travel with each read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_col   <= '0;
         rd_pend  <= 1'b0;
         rd_valid <= 1'b0;
         rd_hs    <= 1'b0;
      end else begin
         rd_pend <= pix2_ce;
         if (pix2_ce) begin
            rd_valid <= valid;
            rd_hs    <= (rd_col < HS_COLS);
         end
         if (line_start)
            rd_col <= '0;
         else if (pix2_ce)
            rd_col <= rd_wrap ? '0 : rd_col + 1'b1;
      end
   end

   // Channel level for one colour bit given the intensity bit.
   function automatic logic [5:0] level(input logic c, input logic i);
      return c ? (i ? 6'(LVL_HI) : 6'(LVL_LO)) : 6'd0;
   endfunction

   // Output register: palette expansion, blanking and hsync, one clk after the read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vga_r    <= '0;
         vga_g    <= '0;
         vga_b    <= '0;
         vga_hs_n <= 1'b1;
      end else if (rd_pend) begin
         vga_r    <= rd_valid ? level(rd_data[1], rd_data[0]) : 6'd0;
         vga_g    <= rd_valid ? level(rd_data[2], rd_data[0]) : 6'd0;
         vga_b    <= rd_valid ? level(rd_data[3], rd_data[0]) : 6'd0;
         vga_hs_n <= ~rd_hs;
      end
   end

endmodule

// File: tb/tb_scandoubler_vga.sv
// Testbench for scandoubler_vga: table-driven line schedule and palette
// vectors, random pixel data, and a line-level reference model built from
// queues of captured pixels.
module tb_scandoubler_vga;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pix_ce;
   logic       pix2_ce;
   logic [3:0] rgbi_in;
   logic       hsync_n_in;
   logic       vsync_n_in;
   logic [5:0] vga_r, vga_g, vga_b;
   logic       vga_hs_n, vga_vs_n;
   logic [8:0] line_len;

   int n_vec = 0;
   int n_err = 0;

   scandoubler_vga dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .pix_ce     (pix_ce),
      .pix2_ce    (pix2_ce),
      .rgbi_in    (rgbi_in),
      .hsync_n_in (hsync_n_in),
      .vsync_n_in (vsync_n_in),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b),
      .vga_hs_n   (vga_hs_n),
      .vga_vs_n   (vga_vs_n),
      .line_len   (line_len)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] rgbi;
      int         r, g, b;
   } pal_vec_t;

   typedef struct {
      int len;      // pixels in the input line
      bit vs_n;     // vsync level held for the whole line
      int mode;     // 0: (col+base)&15, 1: random, 2: constant base
      int base;
      int exp_len;  // line_len expected once this line is complete
   } line_vec_t;

   // ---------------- reference model ----------------
   logic [3:0] cur[$];    // pixels of the line being captured
   logic [3:0] disp[$];   // line being replayed
   int         disp_len, rd_idx;
   bit         valid_m, seen_m, hs_prev_m, vs_prev_m;
   bit         pend_m, pend_valid;
   logic [3:0] pend_px;
   int         pend_idx;
   int         exp_r, exp_g, exp_b, exp_hs, exp_vs, exp_len;

   function automatic int lvl(input bit c, input bit i);
      return c ? (i ? 63 : 42) : 0;
   endfunction

   task automatic model_reset();
      cur.delete();
      cur.push_back(4'h0);   // address 0 is skipped before the first line start
      disp.delete();
      disp_len  = 0;
      rd_idx    = 0;
      valid_m   = 0;
      seen_m    = 0;
      hs_prev_m = 1;
      vs_prev_m = 1;
      pend_m    = 0;
      exp_r = 0; exp_g = 0; exp_b = 0;
      exp_hs = 1; exp_vs = 1; exp_len = 0;
   endtask

   task automatic model_edge(input bit pce, input bit p2ce, input logic [3:0] px,
                             input bit hs, input bit vs);
      bit ls;
      ls = pce && hs_prev_m && !hs;
      if (pend_m) begin
         exp_r  = pend_valid ? lvl(pend_px[1], pend_px[0]) : 0;
         exp_g  = pend_valid ? lvl(pend_px[2], pend_px[0]) : 0;
         exp_b  = pend_valid ? lvl(pend_px[3], pend_px[0]) : 0;
         exp_hs = (pend_idx < 16) ? 0 : 1;
      end
      pend_m = p2ce;
      if (p2ce) begin
         pend_valid = valid_m;
         pend_px    = (valid_m && rd_idx < disp.size()) ? disp[rd_idx] : 4'h0;
         pend_idx   = rd_idx;
      end
      if (ls) begin
         disp     = cur;
         disp_len = (cur.size() > 511) ? 511 : cur.size();
         exp_len  = disp_len;
         rd_idx   = 0;
         valid_m  = seen_m;
         seen_m   = 1;
         exp_vs   = vs_prev_m;
         cur.delete();
         cur.push_back(px);
      end else begin
         if (p2ce) rd_idx = (disp_len == 0 || rd_idx + 1 >= disp_len) ? 0 : rd_idx + 1;
         if (pce) begin
            if (cur.size() < 512) cur.push_back(px);
            else cur[511] = px;
         end
      end
      if (pce) begin
         hs_prev_m = hs;
         vs_prev_m = vs;
      end
   endtask

   // ---------------- checking ----------------
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic compare_all();
      check("vga_r",    vga_r,    exp_r);
      check("vga_g",    vga_g,    exp_g);
      check("vga_b",    vga_b,    exp_b);
      check("vga_hs_n", vga_hs_n, exp_hs);
      check("vga_vs_n", vga_vs_n, exp_vs);
      check("line_len", line_len, exp_len);
   endtask

   // One clk: drive, edge, model update, then sample 1 time unit later.
   task automatic cyc(input bit pce, input bit p2ce, input logic [3:0] px,
                      input bit hs, input bit vs);
      pix_ce     = pce;
      pix2_ce    = p2ce;
      rgbi_in    = px;
      hsync_n_in = hs;
      vsync_n_in = vs;
      @(posedge clk);
      model_edge(pce, p2ce, px, hs, vs);
      #1;
      compare_all();
   endtask

   pal_vec_t  pal[4];
   line_vec_t tbl[12];

   // chk: 0 none, 1 palette entry idx of the previous line, 2 expect black.
   task automatic run_line(input int len, input int hs_low, input bit vs, input int mode,
                           input int base, input int chk, input int idx, input int exp_ll);
      logic [3:0] px;
      bit         hs;
      for (int p = 0; p < len; p++) begin
         case (mode)
            0:       px = 4'((p + base) & 15);
            1:       px = 4'($urandom_range(15));
            default: px = 4'(base);
         endcase
         hs = (p < hs_low) ? 1'b0 : 1'b1;
         cyc(1, 1, px, hs, vs);
         if (p == 0 && exp_ll >= 0) check("line_len_tbl", line_len, exp_ll);
         cyc(0, 0, px, hs, vs);
         cyc(0, 1, px, hs, vs);
         cyc(0, 0, px, hs, vs);
         if (p == 20 && chk == 1) begin
            check("pal_r", vga_r, pal[idx].r);
            check("pal_g", vga_g, pal[idx].g);
            check("pal_b", vga_b, pal[idx].b);
         end else if (p == 20 && chk == 2) begin
            check("blank_r", vga_r, 0);
            check("blank_g", vga_g, 0);
            check("blank_b", vga_b, 0);
         end
      end
   endtask

   initial begin
      pal[0] = '{4'b0101,  0, 63,  0};
      pal[1] = '{4'b1110, 42, 42, 42};
      pal[2] = '{4'b0001,  0,  0,  0};
      pal[3] = '{4'b1011, 63,  0, 63};

      tbl[0]  = '{384, 1'b1, 0, 0, 384};
      tbl[1]  = '{384, 1'b1, 1, 0, 384};
      tbl[2]  = '{384, 1'b1, 0, 5, 384};
      tbl[3]  = '{600, 1'b1, 1, 0, 511};
      tbl[4]  = '{384, 1'b1, 0, 3, 384};
      tbl[5]  = '{200, 1'b1, 1, 0, 200};
      tbl[6]  = '{384, 1'b0, 0, 7, 384};
      tbl[7]  = '{384, 1'b0, 1, 0, 384};
      tbl[8]  = '{384, 1'b0, 0, 9, 384};
      tbl[9]  = '{384, 1'b1, 1, 0, 384};
      tbl[10] = '{384, 1'b1, 0, 0, 384};
      tbl[11] = '{100, 1'b1, 0, 2, -1};

      // Power-up reset
      rst_n = 1'b0;
      pix_ce = 0; pix2_ce = 0; rgbi_in = 0; hsync_n_in = 1; vsync_n_in = 1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_r", vga_r, 0);
      check("rst_hs_n", vga_hs_n, 1);
      check("rst_vs_n", vga_vs_n, 1);
      check("rst_line_len", line_len, 0);
      model_reset();
      rst_n = 1'b1;

      // Line schedule: lengths, saturation, truncation, vsync, bank swap
      for (int i = 0; i < 12; i++)
         run_line(tbl[i].len, 32, tbl[i].vs_n, tbl[i].mode, tbl[i].base, 0, 0,
                  (i > 0) ? tbl[i-1].exp_len : -1);

      // Palette: each line is constant, checked while it is replayed
      for (int i = 0; i < 5; i++)
         run_line(64, 8, 1'b1, 2, (i < 4) ? int'(pal[i].rgbi) : 0,
                  (i > 0) ? 1 : 0, (i > 0) ? i - 1 : 0, -1);

      // Reset in the middle of a line
      run_line(100, 32, 1'b1, 2, 15, 0, 0, -1);
      run_line(50, 32, 1'b1, 2, 15, 0, 0, -1);
      rst_n = 1'b0;
      #1;
      check("midrst_r", vga_r, 0);
      check("midrst_g", vga_g, 0);
      check("midrst_b", vga_b, 0);
      check("midrst_hs_n", vga_hs_n, 1);
      check("midrst_vs_n", vga_vs_n, 1);
      check("midrst_line_len", line_len, 0);
      model_reset();
      #2;
      rst_n = 1'b1;
      run_line(30, 0, 1'b1, 1, 0, 2, 0, -1);    // no sync yet
      run_line(384, 32, 1'b1, 1, 0, 2, 0, -1);  // first start: still black
      run_line(384, 32, 1'b1, 0, 4, 0, 0, -1);  // second start: picture
      run_line(384, 32, 1'b1, 1, 0, 0, 0, 384);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
